// File: rtl/wb_inst_responder.sv
// Wishbone instruction responder: serves core reads from a small instruction
// FIFO that a stimulus source fills, and captures core stores for inspection.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a Wishbone request
// RD_WAIT | read pending on an empty FIFO, counting toward timeout
// ACK     | one-cycle acknowledge (plus store-valid for writes)
// ERR     | one-cycle error after a read timed out
module wb_inst_responder #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PAD_WORD = 32'hF0081003,
  parameter int          TIMEOUT  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_inst_valid,
  input  logic [31:0]              i_inst,
  output logic                     o_inst_ready,
  output logic [$clog2(DEPTH):0]   o_fifo_count,
  input  logic [31:0]              i_wb_adr,
  input  logic [15:0]              i_wb_sel,
  input  logic                     i_wb_we,
  input  logic [127:0]             i_wb_dat,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  output logic [127:0]             o_wb_dat,
  output logic                     o_wb_ack,
  output logic                     o_wb_err,
  output logic                     o_wdata_valid,
  output logic [31:0]              o_wdata,
  output logic [31:0]              o_wadr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2,
    ERR     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            is_wr_q, is_wr_d;
  logic [127:0]    wb_dat_q, wb_dat_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     wadr_q, wadr_d;
  logic [31:0]     mem_q [DEPTH];

  logic            req;
  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic            push;
  logic [31:0]     head;

  // Byte selects are carried on the bus but play no part in the response.
  logic            unused_sel;
  assign unused_sel = ^i_wb_sel;

  assign req        = i_wb_cyc & i_wb_stb;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign head       = mem_q[rd_ptr_q];

  // A full FIFO still takes a push in the cycle it is being popped, so the
  // slot freed by the read is refilled and occupancy holds at DEPTH.
  assign o_inst_ready = !fifo_full | pop;
  assign push         = i_inst_valid & o_inst_ready & !i_rst;

  // Popped word goes to the addressed lane; the other lanes carry filler.
  function automatic logic [127:0] lane_fill(input logic [31:0] w, input logic [1:0] lane);
    logic [127:0] r;
    r = {4{PAD_WORD}};
    r[32*lane +: 32] = w;
    return r;
  endfunction

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Bus FSM next-state, pop decision and captured data.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    is_wr_d    = is_wr_q;
    wb_dat_d   = wb_dat_q;
    wdata_d    = wdata_q;
    wadr_d     = wadr_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (i_wb_we) begin
            wadr_d  = i_wb_adr;
            wdata_d = i_wb_dat[32*i_wb_adr[3:2] +: 32];
            is_wr_d = 1'b1;
            state_d = ACK;
          end else if (!fifo_empty) begin
            pop      = 1'b1;
            wb_dat_d = lane_fill(head, i_wb_adr[3:2]);
            is_wr_d  = 1'b0;
            state_d  = ACK;
          end else begin
            is_wr_d    = 1'b0;
            wait_cnt_d = '0;
            state_d    = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (!fifo_empty) begin
          pop      = 1'b1;
          wb_dat_d = lane_fill(head, i_wb_adr[3:2]);
          state_d  = ACK;
        end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
          wb_dat_d = {4{PAD_WORD}};
          state_d  = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      ACK:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_cnt_q <= '0;
      is_wr_q    <= 1'b0;
      wb_dat_q   <= '0;
      wdata_q    <= '0;
      wadr_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wait_cnt_q <= wait_cnt_d;
      is_wr_q    <= is_wr_d;
      wb_dat_q   <= wb_dat_d;
      wdata_q    <= wdata_d;
      wadr_q     <= wadr_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_inst;
  end

  assign o_fifo_count  = count_q;
  assign o_wb_dat      = wb_dat_q;
  assign o_wdata       = wdata_q;
  assign o_wadr        = wadr_q;
  assign o_wb_ack      = (state_q == ACK);
  assign o_wb_err      = (state_q == ERR);
  assign o_wdata_valid = (state_q == ACK) & is_wr_q;

endmodule
